// File: rtl/pick_pkg.sv
// Shared encodings for the pick dir command bus, used by the encoder and the mover.
package pick_pkg;

  typedef enum logic [2:0] {
    DIR_STOP      = 3'b000,
    DIR_UP_SLOW   = 3'b001,
    DIR_DOWN_SLOW = 3'b010,
    DIR_DOWN_FAST = 3'b011,
    DIR_UP_FAST   = 3'b100
  } dir_t;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_UP   = 2'd1,
    CLS_DOWN = 2'd2
  } key_class_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLOW_UP,
    ST_FAST_UP,
    ST_SLOW_DOWN,
    ST_FAST_DOWN
  } pick_state_t;

  localparam logic [7:0] DEFAULT_KEY_UP       = 8'h1A;
  localparam logic [7:0] DEFAULT_KEY_DOWN     = 8'h16;
  localparam logic [7:0] DEFAULT_KEY_UP_ALT   = 8'h52;
  localparam logic [7:0] DEFAULT_KEY_DOWN_ALT = 8'h51;

  function automatic dir_t state_dir(input pick_state_t s);
    case (s)
      ST_SLOW_UP:   return DIR_UP_SLOW;
      ST_FAST_UP:   return DIR_UP_FAST;
      ST_SLOW_DOWN: return DIR_DOWN_SLOW;
      ST_FAST_DOWN: return DIR_DOWN_FAST;
      default:      return DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/key_class_debounce.sv
// Classifies the HID keycode into NONE/UP/DOWN and only accepts a new class after
// DEBOUNCE_FRAMES consecutive identical samples.
module key_class_debounce
  import pick_pkg::*;
#(
  parameter logic [7:0] KEY_UP          = DEFAULT_KEY_UP,
  parameter logic [7:0] KEY_DOWN        = DEFAULT_KEY_DOWN,
  parameter logic [7:0] KEY_UP_ALT      = DEFAULT_KEY_UP_ALT,
  parameter logic [7:0] KEY_DOWN_ALT    = DEFAULT_KEY_DOWN_ALT,
  parameter int         DEBOUNCE_FRAMES = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output key_class_t accepted
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

  key_class_t sample_class;
  key_class_t cand_reg, cand_next;
  key_class_t acc_reg;
  logic [3:0] stab_reg, stab_next;

  always_comb begin
    if (keycode == KEY_UP || keycode == KEY_UP_ALT)
      sample_class = CLS_UP;
    else if (keycode == KEY_DOWN || keycode == KEY_DOWN_ALT)
      sample_class = CLS_DOWN;
    else
      sample_class = CLS_NONE;
  end

  // accepted reflects the post-edge view so the FSM reacts on the accepting edge itself
  always_comb begin
    cand_next = cand_reg;
    stab_next = stab_reg;
    if (sample_class != cand_reg) begin
      cand_next = sample_class;
      stab_next = 4'd1;
    end else if (stab_reg < DEB) begin
      stab_next = stab_reg + 4'd1;
    end
    accepted = (stab_next == DEB) ? cand_next : acc_reg;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cand_reg <= CLS_NONE;
      stab_reg <= DEB;
      acc_reg  <= CLS_NONE;
    end else begin
      cand_reg <= cand_next;
      stab_reg <= stab_next;
      acc_reg  <= accepted;
    end
  end

endmodule

// File: rtl/pick_dir_encoder.sv
// Turns the debounced key class into dir motion codes, escalating a held key
// from slow to fast after HOLD_FRAMES.
module pick_dir_encoder
  import pick_pkg::*;
#(
  parameter logic [7:0] KEY_UP          = DEFAULT_KEY_UP,
  parameter logic [7:0] KEY_DOWN        = DEFAULT_KEY_DOWN,
  parameter logic [7:0] KEY_UP_ALT      = DEFAULT_KEY_UP_ALT,
  parameter logic [7:0] KEY_DOWN_ALT    = DEFAULT_KEY_DOWN_ALT,
  parameter int         DEBOUNCE_FRAMES = 2,
  parameter int         HOLD_FRAMES     = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic [2:0] dir,
  output logic       fast
);

  localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

  key_class_t  acc_class;
  pick_state_t state_reg, state_next;
  logic [7:0]  hold_reg, hold_next, hold_inc;
  dir_t        dir_reg;
  logic        fast_reg;

  key_class_debounce #(
    .KEY_UP          (KEY_UP),
    .KEY_DOWN        (KEY_DOWN),
    .KEY_UP_ALT      (KEY_UP_ALT),
    .KEY_DOWN_ALT    (KEY_DOWN_ALT),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .accepted  (acc_class)
  );

  // The entry frame counts as the first slow frame, so entry loads 1.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    hold_inc   = hold_reg + 8'd1;
    case (acc_class)
      CLS_UP: begin
        case (state_reg)
          ST_SLOW_UP: begin
            hold_next = hold_inc;
            if (hold_inc >= HOLD) state_next = ST_FAST_UP;
          end
          ST_FAST_UP: begin
          end
          default: begin
            state_next = ST_SLOW_UP;
            hold_next  = 8'd1;
          end
        endcase
      end
      CLS_DOWN: begin
        case (state_reg)
          ST_SLOW_DOWN: begin
            hold_next = hold_inc;
            if (hold_inc >= HOLD) state_next = ST_FAST_DOWN;
          end
          ST_FAST_DOWN: begin
          end
          default: begin
            state_next = ST_SLOW_DOWN;
            hold_next  = 8'd1;
          end
        endcase
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      hold_reg  <= 8'd0;
      dir_reg   <= DIR_STOP;
      fast_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      dir_reg   <= state_dir(state_next);
      fast_reg  <= (state_next == ST_FAST_UP) || (state_next == ST_FAST_DOWN);
    end
  end

  assign dir  = dir_reg;
  assign fast = fast_reg;

endmodule

// File: tb/tb_pick_dir_encoder.sv
// Directed bench for pick_dir_encoder; expected {fast,dir} values are hand-computed.
`timescale 1ns/1ps
module tb_pick_dir_encoder;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic [2:0] dir;
  logic       fast;

  int checks = 0;
  int errors = 0;

  pick_dir_encoder dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .dir       (dir),
    .fast      (fast)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, want done");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // n edges with keycode held; edges before sw expect pre, from sw on expect post ({fast,dir})
  task automatic expect_seq(input string tag, input logic [7:0] kc, input int n, input int sw,
                            input logic [3:0] pre, input logic [3:0] post);
    keycode = kc;
    for (int e = 1; e <= n; e++) begin
      tick();
      check_val($sformatf("%s e%0d", tag, e), {28'd0, fast, dir}, (e < sw) ? {28'd0, pre} : {28'd0, post});
    end
    $display("seg %-14s key=%02h edges=%0d -> {fast,dir}=%b", tag, kc, n, {fast, dir});
  endtask

  initial begin
    Reset   = 1'b1;
    keycode = 8'h00;
    tick();
    tick();
    check_val("reset_state", {28'd0, fast, dir}, 32'd0);
    Reset = 1'b0;

    expect_seq("idle_00", 8'h00, 10, 1, 4'b0000, 4'b0000);

    // W held: slow at edge 2, fast at edge 31
    expect_seq("up_slow", 8'h1A, 30, 2, 4'b0000, 4'b0001);
    expect_seq("up_fast", 8'h1A, 5, 1, 4'b0000, 4'b1100);

    // reversal from fast: one debounce edge, then slow, then fast 29 edges later
    expect_seq("rev_down", 8'h16, 30, 2, 4'b1100, 4'b0010);
    expect_seq("down_fast", 8'h16, 3, 1, 4'b0000, 4'b1011);
    expect_seq("rev_up", 8'h1A, 30, 2, 4'b1011, 4'b0001);
    expect_seq("rev_up_fast", 8'h1A, 3, 1, 4'b0000, 4'b1100);

    // one-frame glitch while slow must not dip to idle
    expect_seq("to_idle", 8'h00, 2, 2, 4'b1100, 4'b0000);
    expect_seq("slow_pre", 8'h1A, 7, 2, 4'b0000, 4'b0001);
    expect_seq("glitch", 8'h00, 1, 1, 4'b0000, 4'b0001);
    expect_seq("slow_post", 8'h1A, 5, 1, 4'b0000, 4'b0001);

    // unknown keycode and alternate arrows
    expect_seq("idle2", 8'h00, 2, 2, 4'b0001, 4'b0000);
    expect_seq("unknown_04", 8'h04, 20, 1, 4'b0000, 4'b0000);
    expect_seq("alt_up_52", 8'h52, 2, 2, 4'b0000, 4'b0001);
    expect_seq("idle3", 8'h00, 2, 2, 4'b0001, 4'b0000);
    expect_seq("alt_dn_51", 8'h51, 2, 2, 4'b0000, 4'b0010);
    expect_seq("idle4", 8'h00, 2, 2, 4'b0010, 4'b0000);

    // async reset mid-fast with the key still held
    expect_seq("pre_rst_slow", 8'h1A, 30, 2, 4'b0000, 4'b0001);
    expect_seq("pre_rst_fast", 8'h1A, 3, 1, 4'b0000, 4'b1100);
    #1;
    Reset = 1'b1;
    #1;
    check_val("async_reset", {28'd0, fast, dir}, 32'd0);
    #1;
    Reset = 1'b0;
    expect_seq("post_rst_slow", 8'h1A, 30, 2, 4'b0000, 4'b0001);
    expect_seq("post_rst_fast", 8'h1A, 3, 1, 4'b0000, 4'b1100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
